// File: rtl/dpu_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : dpu_disp_scan
//  Description : Latches the DPU result, opcode and display select, then
//                scans them onto a 4-digit common-anode seven-segment display
//                with a blanked dead-time between digit slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpu_disp_scan #(
    parameter int DIV  = 16,    // cycles each digit is lit per slot (>=2)
    parameter int DEAD = 2,     // cycles all digits are off between slots (>=1)
    parameter bit LZB  = 1'b1   // blank digit 1 when latched dout[7:4]==0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       hold,
    input  logic [7:0] dout,
    input  logic [2:0] alu_op,
    input  logic [1:0] dsel,
    output logic [6:0] seg,      // seg[6]=a ... seg[0]=g, active-low
    output logic [3:0] an,       // an[0] = digit 0, active-low
    output logic [7:0] cur_val
);

    // One counter serves both phases, so size it for the longer one.
    localparam int c_cmax = (DIV > DEAD) ? DIV : DEAD;
    localparam int c_cw   = (c_cmax > 1) ? $clog2(c_cmax) : 1;

    localparam logic [c_cw-1:0] c_div_last  = c_cw'(DIV - 1);
    localparam logic [c_cw-1:0] c_dead_last = c_cw'(DEAD - 1);
    localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);

    localparam logic [0:0] c_st_dead = 1'b0;
    localparam logic [0:0] c_st_show = 1'b1;

    logic [7:0]      r_cur_val;
    logic [2:0]      r_op_q;
    logic [1:0]      r_dsel_q;
    logic [0:0]      r_state;
    logic [1:0]      r_idx;
    logic [c_cw-1:0] r_cnt;
    logic [6:0]      r_seg;      // doubles as the per-slot segment pattern
    logic [3:0]      r_an;

    logic [3:0]      w_nib;
    logic            w_blank;
    logic [6:0]      w_pat;
    logic [3:0]      w_an_on;

    // Hex to active-low segments, MSB = a, LSB = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        seg_decode = 7'b1111111;
        case (v)
            4'h0: seg_decode = 7'b0000001;
            4'h1: seg_decode = 7'b1001111;
            4'h2: seg_decode = 7'b0010010;
            4'h3: seg_decode = 7'b0000110;
            4'h4: seg_decode = 7'b1001100;
            4'h5: seg_decode = 7'b0100100;
            4'h6: seg_decode = 7'b0100000;
            4'h7: seg_decode = 7'b0001111;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0000100;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b1100000;
            4'hC: seg_decode = 7'b0110001;
            4'hD: seg_decode = 7'b1000010;
            4'hE: seg_decode = 7'b0110000;
            4'hF: seg_decode = 7'b0111000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Select the nibble for the digit about to be lit and build its pattern.
    always_comb begin
        w_nib = 4'h0;
        case (r_idx)
            2'd0:    w_nib = r_cur_val[3:0];
            2'd1:    w_nib = r_cur_val[7:4];
            2'd2:    w_nib = {1'b0, r_op_q};
            default: w_nib = {2'b00, r_dsel_q};
        endcase
        w_blank = LZB && (r_idx == 2'd1) && (r_cur_val[7:4] == 4'h0);
        w_pat   = w_blank ? 7'b1111111 : seg_decode(w_nib);
        w_an_on = ~(4'b0001 << r_idx);
    end

    // Capture register: frozen while hold is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_val <= 8'h00;
            r_op_q    <= 3'd0;
            r_dsel_q  <= 2'd0;
        end else if (ld && !hold) begin
            r_cur_val <= dout;
            r_op_q    <= alu_op;
            r_dsel_q  <= dsel;
        end
    end

    // Scan FSM; an/seg are loaded on the phase edges so they track the state
    // exactly and the pattern stays fixed for the whole lit slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_dead;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_an    <= 4'b1111;
            r_seg   <= 7'b1111111;
        end else begin
            case (r_state)
                c_st_dead: begin
                    if (r_cnt == c_dead_last) begin
                        r_state <= c_st_show;
                        r_cnt   <= '0;
                        r_an    <= w_an_on;
                        r_seg   <= w_pat;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    if (r_cnt == c_div_last) begin
                        r_state <= c_st_dead;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + 2'd1;
                        r_an    <= 4'b1111;
                        r_seg   <= 7'b1111111;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
            endcase
        end
    end

    assign seg     = r_seg;
    assign an      = r_an;
    assign cur_val = r_cur_val;

endmodule
`default_nettype wire

// File: tb/tb_dpu_disp_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpu_disp_scan
//  Description : Scoreboard bench for dpu_disp_scan (LZB=1 and LZB=0 copies
//                run in lockstep from the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dpu_disp_scan;

    localparam int DIV  = 16;
    localparam int DEAD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] dout;
    logic [2:0] alu_op;
    logic [1:0] dsel;
    logic [6:0] seg, seg2;
    logic [3:0] an, an2;
    logic [7:0] cur_val, cur_val2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg2;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    dpu_disp_scan #(.DIV(DIV), .DEAD(DEAD), .LZB(1'b1)) u_dut (
        .clk(clk), .rst(rst), .ld(ld), .hold(hold), .dout(dout),
        .alu_op(alu_op), .dsel(dsel), .seg(seg), .an(an), .cur_val(cur_val));

    dpu_disp_scan #(.DIV(DIV), .DEAD(DEAD), .LZB(1'b0)) u_dut_nolzb (
        .clk(clk), .rst(rst), .ld(ld), .hold(hold), .dout(dout),
        .alu_op(alu_op), .dsel(dsel), .seg(seg2), .an(an2), .cur_val(cur_val2));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] model_seg(input int d, input logic [7:0] v,
                                             input logic [2:0] op, input logic [1:0] ds,
                                             input bit lzb);
        logic [3:0] nib;
        case (d)
            0:       nib = v[3:0];
            1:       nib = v[7:4];
            2:       nib = {1'b0, op};
            default: nib = {2'b00, ds};
        endcase
        if (lzb && d == 1 && v[7:4] == 4'h0) return 7'b1111111;
        return seg_tab[nib];
    endfunction

    task automatic push_scan(input logic [7:0] v, input logic [2:0] op, input logic [1:0] ds);
        exp_t e;
        logic [3:0] one;
        one = 4'b0001;
        for (int d = 0; d < 4; d++) begin
            e.an   = ~(one << d);
            e.seg  = model_seg(d, v, op, ds, 1'b1);
            e.seg2 = model_seg(d, v, op, ds, 1'b0);
            sb.push_back(e);
        end
    endtask

    task automatic do_ld(input logic [7:0] v, input logic [2:0] op, input logic [1:0] ds);
        @(posedge clk); #1;
        ld = 1'b1; dout = v; alu_op = op; dsel = ds;
        @(posedge clk); #1;
        ld = 1'b0; dout = 'x; alu_op = 'x; dsel = 'x;
        @(negedge clk);
    endtask

    // Measures the next lit slot; must be called at a negedge sample point.
    task automatic wait_slot(output logic [3:0] a, output logic [6:0] s, output logic [6:0] s2,
                             output int lit, output int dead, output bit stable, output bit ok);
        int n;
        ok = 1'b1; stable = 1'b1; lit = 0; dead = 0; n = 0;
        a = 4'hF; s = 7'h7F; s2 = 7'h7F;
        while (an != 4'hF && n < 100) begin @(negedge clk); n++; end
        while (an == 4'hF && n < 100) begin @(negedge clk); dead++; n++; end
        if (n >= 100) begin ok = 1'b0; return; end
        a = an; s = seg; s2 = seg2; n = 0;
        while (an == a && n < 100) begin
            if (seg !== s || seg2 !== s2 || an2 !== a) stable = 1'b0;
            lit++; n++;
            @(negedge clk);
        end
        if (n >= 100) ok = 1'b0;
    endtask

    // Returns at the start of the dead gap preceding digit 0.
    task automatic sync_d3(output bit ok);
        logic [3:0] a; logic [6:0] s, s2; int lit, dead; bit st, k;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            wait_slot(a, s, s2, lit, dead, st, k);
            if (k && a == 4'b0111) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n;
        dout = 'x; alu_op = 'x; dsel = 'x; ld = 1'b0; hold = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || cur_val !== 8'h00 || seg2 !== 7'h7F) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%b cur_val=%h, expected 1111 1111111 00", an, seg, cur_val);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n = 0;
        while (an == 4'hF && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (n != DEAD || an !== 4'b1110 || seg !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_first_digit: dead=%0d an=%b seg=%b, expected dead=%0d an=1110 seg=0000001", n, an, seg, DEAD);
        end
        do_ld(8'h5C, 3'd3, 2'd1);
        checks++;
        if (cur_val !== 8'h5C) begin
            errors++;
            $display("FAIL reset_preload: cur_val=%h expected 5c", cur_val);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || cur_val !== 8'h00 || an2 !== 4'hF) begin
            errors++;
            $display("FAIL reset_async: an=%b seg=%b cur_val=%h, expected 1111 1111111 00", an, seg, cur_val);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n = 0;
        while (an == 4'hF && n < 50) begin n++; @(negedge clk); end
        checks++;
        if (n != DEAD || an !== 4'b1110 || seg !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_restart: dead=%0d an=%b seg=%b, expected dead=%0d an=1110 seg=0000001", n, an, seg, DEAD);
        end
    endtask

    task automatic test_scan();
        exp_t e; logic [3:0] a; logic [6:0] s, s2; int lit, dead; bit st, ok;
        do_ld(8'h3A, 3'd5, 2'd2);
        checks++;
        if (cur_val !== 8'h3A) begin errors++; $display("FAIL scan_capture: cur_val=%h expected 3a", cur_val); end
        sync_d3(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_sync: digit-3 slot not found"); end
        push_scan(8'h3A, 3'd5, 2'd2);
        push_scan(8'h3A, 3'd5, 2'd2);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_slot(a, s, s2, lit, dead, st, ok);
            checks++;
            if (!ok || a !== e.an || s !== e.seg || s2 !== e.seg2) begin
                errors++;
                $display("FAIL scan_slot: got an=%b seg=%b seg_nolzb=%b, expected an=%b seg=%b seg_nolzb=%b", a, s, s2, e.an, e.seg, e.seg2);
            end
            checks++;
            if (lit != DIV || dead != DEAD || !st) begin
                errors++;
                $display("FAIL scan_timing: lit=%0d dead=%0d stable=%0d, expected lit=%0d dead=%0d stable=1", lit, dead, st, DIV, DEAD);
            end
        end
    endtask

    task automatic test_lzb();
        exp_t e; logic [3:0] a; logic [6:0] s, s2; int lit, dead; bit st, ok;
        do_ld(8'h07, 3'd0, 2'd0);
        sync_d3(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL lzb_sync: digit-3 slot not found"); end
        push_scan(8'h07, 3'd0, 2'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_slot(a, s, s2, lit, dead, st, ok);
            checks++;
            if (!ok || a !== e.an || s !== e.seg || s2 !== e.seg2) begin
                errors++;
                $display("FAIL lzb_slot: got an=%b seg=%b seg_nolzb=%b, expected an=%b seg=%b seg_nolzb=%b", a, s, s2, e.an, e.seg, e.seg2);
            end
            checks++;
            if (lit != DIV || dead != DEAD || !st) begin
                errors++;
                $display("FAIL lzb_timing: lit=%0d dead=%0d stable=%0d, expected lit=%0d dead=%0d stable=1", lit, dead, st, DIV, DEAD);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e; logic [3:0] a; logic [6:0] s, s2; int lit, dead; bit st, ok;
        do_ld(8'h12, 3'd1, 2'd1);
        @(posedge clk); #1;
        hold = 1'b1; ld = 1'b1; dout = 8'hFF; alu_op = 3'd7; dsel = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        ld = 1'b0; dout = 'x; alu_op = 'x; dsel = 'x;
        @(negedge clk);
        checks++;
        if (cur_val !== 8'h12 || cur_val2 !== 8'h12) begin
            errors++;
            $display("FAIL hold_capture: cur_val=%h expected 12", cur_val);
        end
        sync_d3(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_sync: digit-3 slot not found"); end
        push_scan(8'h12, 3'd1, 2'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_slot(a, s, s2, lit, dead, st, ok);
            checks++;
            if (!ok || a !== e.an || s !== e.seg || s2 !== e.seg2) begin
                errors++;
                $display("FAIL hold_slot: got an=%b seg=%b seg_nolzb=%b, expected an=%b seg=%b seg_nolzb=%b", a, s, s2, e.an, e.seg, e.seg2);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_midslot();
        exp_t e; logic [3:0] a; logic [6:0] s, s2; int lit, dead, n; bit st, ok;
        do_ld(8'h00, 3'd0, 2'd0);
        sync_d3(ok);
        n = 0;
        while (an != 4'b1110 && n < 10) begin n++; @(negedge clk); end
        checks++;
        if (!ok || an !== 4'b1110 || seg !== 7'b0000001) begin
            errors++;
            $display("FAIL mid_sync: an=%b seg=%b, expected 1110 0000001", an, seg);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        ld = 1'b1; dout = 8'h0F; alu_op = 3'd0; dsel = 2'd0;
        @(posedge clk); #1;
        ld = 1'b0; dout = 'x; alu_op = 'x; dsel = 'x;
        @(negedge clk);
        checks++;
        if (cur_val !== 8'h0F) begin errors++; $display("FAIL mid_capture: cur_val=%h expected 0f", cur_val); end
        st = 1'b1; n = 0;
        while (an == 4'b1110 && n < 30) begin
            if (seg !== 7'b0000001) st = 1'b0;
            n++; @(negedge clk);
        end
        checks++;
        if (!st) begin errors++; $display("FAIL mid_hold_slot: seg changed inside slot, expected 0000001 throughout"); end
        push_scan(8'h0F, 3'd0, 2'd0);
        e = sb.pop_front();
        sb.push_back(e);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_slot(a, s, s2, lit, dead, st, ok);
            checks++;
            if (!ok || a !== e.an || s !== e.seg || s2 !== e.seg2) begin
                errors++;
                $display("FAIL mid_slot: got an=%b seg=%b seg_nolzb=%b, expected an=%b seg=%b seg_nolzb=%b", a, s, s2, e.an, e.seg, e.seg2);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t e; logic [3:0] a; logic [6:0] s, s2; int lit, dead; bit st, ok;
        logic [7:0] v; logic [2:0] op; logic [1:0] ds;
        for (int i = 0; i < 16; i++) begin
            v = 8'(17 * i); op = 3'(i % 8); ds = 2'(i % 4);
            do_ld(v, op, ds);
            checks++;
            if (cur_val !== v) begin errors++; $display("FAIL sweep_capture: cur_val=%h expected %h", cur_val, v); end
            sync_d3(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL sweep_sync: digit-3 slot not found (value %h)", v); end
            push_scan(v, op, ds);
            push_scan(v, op, ds);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                wait_slot(a, s, s2, lit, dead, st, ok);
                checks++;
                if (!ok || a !== e.an || s !== e.seg || s2 !== e.seg2) begin
                    errors++;
                    $display("FAIL sweep_slot: value=%h got an=%b seg=%b seg_nolzb=%b, expected an=%b seg=%b seg_nolzb=%b", v, a, s, s2, e.an, e.seg, e.seg2);
                end
                checks++;
                if (lit != DIV || dead != DEAD || !st) begin
                    errors++;
                    $display("FAIL sweep_timing: lit=%0d dead=%0d stable=%0d, expected lit=%0d dead=%0d stable=1", lit, dead, st, DIV, DEAD);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_hold();
        test_midslot();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
